// File: rtl/pipe_sequencer_pkg.sv
// pipe_sequencer_pkg: shared types, ISA exception codes, sequencer states and execution modes
package pipe_sequencer_pkg;
  localparam int WORD_ADDR_W = 30;
  localparam int ISA_EXP_W = 3;
  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [ISA_EXP_W-1:0] isa_exp_t;
  localparam isa_exp_t ISA_EXP_NO_EXP = 3'd0;
  localparam isa_exp_t ISA_EXP_EXT_INT = 3'd1;
  localparam isa_exp_t ISA_EXP_UNDEF_INSN = 3'd2;
  localparam isa_exp_t ISA_EXP_OVERFLOW = 3'd3;
  localparam isa_exp_t ISA_EXP_MISS_ALIGN = 3'd4;
  localparam isa_exp_t ISA_EXP_PRV_VIO = 3'd5;
  localparam logic CPU_KERNEL_MODE = 1'b0;
  localparam logic CPU_USER_MODE = 1'b1;
  typedef enum logic {SEQ_ST_RUN = 1'b0, SEQ_ST_REFILL = 1'b1} seq_st_e;
endpackage

// File: rtl/pipe_seq_perf.sv
// pipe_seq_perf: three saturating performance counters (stall, flush, exception/irq taken)
//  Exists only when PIPE_SEQ_PERF_EN is defined.
//  Ports: clk, reset_ (async active-low), inc[2:0] per-counter increment, cnt[2:0] counter values.
`ifdef PIPE_SEQ_PERF_EN
module pipe_seq_perf #(
  parameter int PERF_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic [2:0]             inc,
  output logic [2:0][PERF_W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) cnt <= '0;
    else for (int i = 0; i < 3; i++) if (inc[i] && !(&cnt[i])) cnt[i] <= cnt[i] + PERF_W'(1);
  end
endmodule
`endif

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: stall/flush sequencer for the IF/ID/EX/MEM pipeline, owns EPC, exception code and mode
//  Inputs: clk, reset_ (async active-low), if_busy, mem_busy, ld_hazard, mem_en, mem_pc, mem_exp_code,
//          mem_eret, irq (level, pre-masked).
//  Outputs: per-stage stall/flush, new_pc (valid with if_flush), exe_mode, epc, exp_code.
//  PIPE_SEQ_PERF_EN adds perf_stall_cnt, perf_flush_cnt, perf_exp_cnt (PERF_W bits, saturating).
module pipe_sequencer
  import pipe_sequencer_pkg::*;
#(
  parameter word_addr_t EXP_VECTOR = 30'h0000_0100,
  parameter int         REFILL_CYC = 3
`ifdef PIPE_SEQ_PERF_EN
  ,
  parameter int         PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       if_busy,
  input  logic       mem_busy,
  input  logic       ld_hazard,
  input  logic       mem_en,
  input  word_addr_t mem_pc,
  input  isa_exp_t   mem_exp_code,
  input  logic       mem_eret,
  input  logic       irq,
  output logic       if_stall,
  output logic       id_stall,
  output logic       ex_stall,
  output logic       mem_stall,
  output logic       if_flush,
  output logic       id_flush,
  output logic       ex_flush,
  output logic       mem_flush,
  output word_addr_t new_pc,
  output logic       exe_mode,
  output word_addr_t epc,
  output isa_exp_t   exp_code
`ifdef PIPE_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_exp_cnt
`endif
);
  localparam logic [2:0] REFILL_INIT = 3'(REFILL_CYC);
  seq_st_e state, state_nxt;
  logic [2:0] refill_cnt, cnt_nxt;
  logic busy, exp_hit, irq_hit, eret_hit, trap, redirect, hazard;
  // a bus wait freezes everything, so no event is taken while busy
  assign busy = if_busy | mem_busy;
  assign exp_hit = !busy && mem_en && mem_exp_code != ISA_EXP_NO_EXP;
  // interrupts stay masked until the refetch after a redirect has settled
  assign irq_hit = !busy && mem_en && irq && state == SEQ_ST_RUN && !exp_hit;
  assign eret_hit = !busy && mem_en && mem_eret && !exp_hit && !irq_hit;
  assign trap = exp_hit | irq_hit;
  assign redirect = trap | eret_hit;
  assign hazard = !busy && !redirect && ld_hazard;
  always_comb begin
    if_stall = busy | hazard;
    id_stall = busy | hazard;
    ex_stall = busy;
    mem_stall = busy;
    if_flush = redirect;
    id_flush = redirect;
    ex_flush = redirect | hazard;
    mem_flush = redirect;
    new_pc = trap ? EXP_VECTOR : eret_hit ? epc : '0;
  end
  always_comb begin
    state_nxt = busy ? state : redirect ? SEQ_ST_REFILL :
                (state == SEQ_ST_REFILL && refill_cnt == 3'd1) ? SEQ_ST_RUN : state;
    cnt_nxt = busy ? refill_cnt : redirect ? REFILL_INIT :
              (state == SEQ_ST_REFILL && refill_cnt != 3'd0) ? refill_cnt - 3'd1 : refill_cnt;
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= SEQ_ST_RUN;
      refill_cnt <= '0;
      epc <= '0;
      exp_code <= ISA_EXP_NO_EXP;
      exe_mode <= CPU_KERNEL_MODE;
    end else begin
      state <= state_nxt;
      refill_cnt <= cnt_nxt;
      if (trap) begin
        epc <= mem_pc;
        exp_code <= exp_hit ? mem_exp_code : ISA_EXP_EXT_INT;
        exe_mode <= CPU_KERNEL_MODE;
      end else if (eret_hit) exe_mode <= CPU_USER_MODE;
    end
  end
`ifdef PIPE_SEQ_PERF_EN
  logic [2:0][PERF_W-1:0] perf_cnt;
  pipe_seq_perf #(.PERF_W(PERF_W)) u_perf (
    .clk   (clk),
    .reset_(reset_),
    .inc   ({trap, redirect | hazard, busy | hazard}),
    .cnt   (perf_cnt)
  );
  assign perf_stall_cnt = perf_cnt[0];
  assign perf_flush_cnt = perf_cnt[1];
  assign perf_exp_cnt = perf_cnt[2];
`endif
endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer: randomized scoreboard bench for pipe_sequencer against a behavioural model
module tb_pipe_sequencer;
  localparam int REFILL_CYC = 3;
  localparam logic [29:0] EXP_VECTOR = 30'h100;
  typedef struct {
    logic [7:0]  ctrl;
    logic [29:0] new_pc;
    logic        mode;
    logic [29:0] epc;
    logic [2:0]  code;
  } exp_t;
  logic clk = 0, reset_ = 0;
  logic if_busy = 0, mem_busy = 0, ld_hazard = 0, mem_en = 0, mem_eret = 0, irq = 0;
  logic [29:0] mem_pc = '0;
  logic [2:0] mem_exp_code = '0;
  logic if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc, epc;
  logic exe_mode;
  logic [2:0] exp_code;
`ifdef PIPE_SEQ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_exp_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  logic [29:0] m_epc = '0;
  logic [2:0] m_code = '0;
  logic m_mode = 0;
  int mask_left = 0;

  pipe_sequencer #(.EXP_VECTOR(EXP_VECTOR), .REFILL_CYC(REFILL_CYC)) dut (
    .clk(clk), .reset_(reset_), .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code), .mem_eret(mem_eret), .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .exe_mode(exe_mode), .epc(epc), .exp_code(exp_code)
`ifdef PIPE_SEQ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_exp_cnt(perf_exp_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] dut_ctrl();
    return {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush};
  endfunction

  // reference: priority rules applied to the current inputs, irq masked for REFILL_CYC non-busy cycles
  task automatic cycle(input logic ifb, input logic memb, input logic ld, input logic en,
                       input logic [29:0] pc, input logic [2:0] code, input logic eret, input logic rq);
    exp_t e;
    logic busy, t_exp, t_irq, t_eret, redir, haz;
    @(posedge clk);
    #1;
    if_busy = ifb; mem_busy = memb; ld_hazard = ld; mem_en = en;
    mem_pc = pc; mem_exp_code = code; mem_eret = eret; irq = rq;
    busy = ifb | memb;
    t_exp = !busy && en && code != 0;
    t_irq = !busy && en && rq && mask_left == 0 && !t_exp;
    t_eret = !busy && en && eret && !t_exp && !t_irq;
    redir = t_exp | t_irq | t_eret;
    haz = !busy && !redir && ld;
    e.ctrl = busy ? 8'b1111_0000 : redir ? 8'b0000_1111 : haz ? 8'b1100_0010 : 8'b0;
    e.new_pc = (t_exp | t_irq) ? EXP_VECTOR : t_eret ? m_epc : 30'h0;
    e.mode = m_mode; e.epc = m_epc; e.code = m_code;
    q.push_back(e);
    if (t_exp | t_irq) begin
      m_epc = pc;
      m_code = t_exp ? code : 3'd1;
      m_mode = 0;
    end else if (t_eret) m_mode = 1;
    if (!busy) begin
      if (mask_left > 0) mask_left--;
      if (redir) mask_left = REFILL_CYC;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 30'h0, 3'd0, 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {24'h0, dut_ctrl()}, 32'h0);
    check({tag, "_new_pc"}, {2'b0, new_pc}, 32'h0);
    check({tag, "_epc"}, {2'b0, epc}, 32'h0);
    check({tag, "_code"}, {29'h0, exp_code}, 32'h0);
    check({tag, "_mode"}, {31'h0, exe_mode}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ctrl", {24'h0, dut_ctrl()}, {24'h0, e.ctrl});
      check("new_pc", {2'b0, new_pc}, {2'b0, e.new_pc});
      check("epc", {2'b0, epc}, {2'b0, e.epc});
      check("exp_code", {29'h0, exp_code}, {29'h0, e.code});
      check("exe_mode", {31'h0, exe_mode}, {31'h0, e.mode});
    end
  end

  initial begin
    #3;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #2 reset_ = 1;
    cycle(0, 0, 1, 0, 30'h0, 3'd0, 0, 0);
    idle();
    cycle(0, 0, 0, 1, 30'h40, 3'd3, 0, 0);
    repeat (3) idle();
    cycle(0, 0, 0, 1, 30'h77, 3'd0, 1, 0);
    repeat (3) idle();
    cycle(0, 0, 0, 1, 30'h50, 3'd4, 0, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 30'h60 + 30'(i), 3'd0, 0, 1);
    repeat (4) idle();
    cycle(0, 1, 0, 1, 30'h80, 3'd2, 0, 1);
    cycle(1, 1, 0, 1, 30'h80, 3'd2, 0, 1);
    cycle(0, 0, 0, 1, 30'h80, 3'd2, 0, 1);
    idle();
    @(posedge clk);
    #1;
    if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; mem_eret = 0; irq = 0; mem_exp_code = 0;
    reset_ = 0;
    #0.5;
    check_reset_vals("async_reset");
    #0.5 reset_ = 1;
    m_epc = '0; m_code = '0; m_mode = 0; mask_left = 0;
    cycle(0, 0, 0, 1, 30'h99, 3'd0, 0, 1);
    repeat (4) idle();
    for (int i = 0; i < 600; i++) begin
      logic en, ex;
      en = $urandom_range(0, 1) == 1;
      ex = $urandom_range(0, 5) == 0;
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, en,
            30'($urandom), ex ? 3'($urandom_range(1, 7)) : 3'd0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
